// File: rtl/dca_lsu_store_formatter_pkg.sv
// Shared configuration helpers for the DCA LSU store formatter.
// These functions play the role of the dca lpara/util constants. Each maps one of the
// top-level configuration selectors to a concrete width or value:
//   LSU_PARA         -> BW_LSU_ELEMENT
//   AXI_PARA         -> BW_AXI_ALEN
//   MATRIX_SIZE_PARA -> MATRIX_NUM_COL
//   TENSOR_PARA      -> BW_TENSOR_SCALAR, INVALID_TENSOR_VALUE
// The package also holds the formatter FSM state type.
package dca_lsu_store_formatter_pkg;

    typedef enum logic [0:0] {
        StIdle  = 1'b0,
        StBurst = 1'b1
    } fmt_state_e;

    function automatic int unsigned get_bw_lsu_element(input int unsigned lsu_para);
        return (lsu_para == 0) ? 16 : 32;
    endfunction

    // AXI4 bursts carry an 8-bit length; narrower AXI configurations use AXI3-style 4 bits.
    function automatic int unsigned get_bw_axi_alen(input int unsigned axi_para);
        return (axi_para == 32) ? 8 : 4;
    endfunction

    function automatic int unsigned get_matrix_num_col(input int unsigned matrix_size_para);
        return matrix_size_para;
    endfunction

    // Format 0 is fp32 and format 1 is fp16.
    function automatic int unsigned get_bw_tensor_scalar(input int unsigned tensor_para);
        return (tensor_para == 0) ? 32 : 16;
    endfunction

    // The invalid marker is the canonical quiet NaN of the tensor format.
    function automatic logic [31:0] get_invalid_tensor_value(input int unsigned tensor_para);
        return (tensor_para == 0) ? 32'h7FC0_0000 : 32'h0000_7E00;
    endfunction

endpackage

// File: rtl/dca_lsu_store_formatter.sv
// DCA LSU store formatter.
// The block accepts one store transaction {col_mask, alen}. It then takes alen+1 tensor rows,
// narrows each scalar to an LSU element and applies the column mask. Each formatted row is
// placed in a single registered output stage that drives the LSU write-data channel.
//
// Ports:
//   clk, rstp             clock; asynchronous active-high reset
//   clear                 synchronous abort back to idle
//   enable                gates every handshake and every state update
//   txn_valid/ready/info  store transaction, info = {col_mask, alen}
//   tensor_valid/ready    tensor row input; column i is at slice i of tensor_row
//   wreq_valid/ready      LSU write beat, carrying wreq_row, wreq_mask and wreq_last
//   txn_done              one-cycle pulse in the cycle after the last beat is accepted
//   invalid_err           only with DCA_LSU_STORE_INVALID_CHECK_EN defined; sticky flag that
//                         is set when a masked-in scalar equals INVALID_TENSOR_VALUE
module dca_lsu_store_formatter
    import dca_lsu_store_formatter_pkg::*;
#(
    parameter int unsigned LSU_PARA         = 0,
    parameter int unsigned AXI_PARA         = 32,
    parameter int unsigned MATRIX_SIZE_PARA = 4,
    parameter int unsigned TENSOR_PARA      = 0,
    localparam int unsigned BW_LSU_ELEMENT   = get_bw_lsu_element(LSU_PARA),
    localparam int unsigned BW_AXI_ALEN      = get_bw_axi_alen(AXI_PARA),
    localparam int unsigned MATRIX_NUM_COL   = get_matrix_num_col(MATRIX_SIZE_PARA),
    localparam int unsigned BW_TENSOR_SCALAR = get_bw_tensor_scalar(TENSOR_PARA)
) (
    input  logic                                       clk,
    input  logic                                       rstp,
    input  logic                                       clear,
    input  logic                                       enable,
    input  logic                                       txn_valid,
    output logic                                       txn_ready,
    input  logic [BW_AXI_ALEN+MATRIX_NUM_COL-1:0]      txn_info,
    input  logic                                       tensor_valid,
    output logic                                       tensor_ready,
    input  logic [MATRIX_NUM_COL*BW_TENSOR_SCALAR-1:0] tensor_row,
    output logic                                       wreq_valid,
    input  logic                                       wreq_ready,
    output logic [MATRIX_NUM_COL*BW_LSU_ELEMENT-1:0]   wreq_row,
    output logic [MATRIX_NUM_COL-1:0]                  wreq_mask,
    output logic                                       wreq_last,
`ifdef DCA_LSU_STORE_INVALID_CHECK_EN
    output logic                                       invalid_err,
`endif
    output logic                                       txn_done
);

    localparam int unsigned ROW_W = MATRIX_NUM_COL * BW_LSU_ELEMENT;

    fmt_state_e                  state_q, state_d;
    logic [MATRIX_NUM_COL-1:0]   col_mask_q, col_mask_d;
    logic [BW_AXI_ALEN-1:0]      alen_q, alen_d;
    logic [BW_AXI_ALEN-1:0]      cnt_q, cnt_d;
    // Set once row number alen has been taken. This keeps alen = max from wrapping early.
    logic                        all_in_q, all_in_d;
    logic                        wvalid_q, wvalid_d;
    logic [ROW_W-1:0]            row_q, row_d;
    logic [MATRIX_NUM_COL-1:0]   mask_q, mask_d;
    logic                        last_q, last_d;
    logic                        done_q, done_d;

    logic                        txn_fire;
    logic                        tensor_fire;
    logic                        wreq_fire;
    logic                        cnt_at_alen;
    logic [ROW_W-1:0]            row_fmt;

    // With narrowing formats the upper scalar bits are dropped on purpose.
    logic unused_tensor_bits;
    assign unused_tensor_bits = ^tensor_row;

    assign txn_ready    = enable & (state_q == StIdle) & ~clear;
    // The output stage can take a new row when it is empty or is draining in this same cycle.
    assign tensor_ready = enable & (state_q == StBurst) & ~clear & (~wvalid_q | wreq_ready)
                          & ~all_in_q;
    assign txn_fire     = txn_valid & txn_ready;
    assign tensor_fire  = tensor_valid & tensor_ready;
    assign wreq_fire    = enable & ~clear & wvalid_q & wreq_ready;
    assign cnt_at_alen  = (cnt_q == alen_q);

    // Narrow or zero-extend each scalar to the element width. Masked-out columns are zero.
    always_comb begin
        row_fmt = '0;
        for (int i = 0; i < int'(MATRIX_NUM_COL); i++) begin
            if (col_mask_q[i]) begin
                row_fmt[i*BW_LSU_ELEMENT +: BW_LSU_ELEMENT] =
                    BW_LSU_ELEMENT'(tensor_row[i*BW_TENSOR_SCALAR +: BW_TENSOR_SCALAR]);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        col_mask_d = col_mask_q;
        alen_d     = alen_q;
        cnt_d      = cnt_q;
        all_in_d   = all_in_q;
        wvalid_d   = wvalid_q;
        row_d      = row_q;
        mask_d     = mask_q;
        last_d     = last_q;
        done_d     = 1'b0;

        if (clear) begin
            state_d  = StIdle;
            cnt_d    = '0;
            all_in_d = 1'b0;
            wvalid_d = 1'b0;
        end else if (enable) begin
            done_d = wreq_fire & last_q;

            unique case (state_q)
                StIdle: begin
                    if (txn_fire) begin
                        state_d    = StBurst;
                        col_mask_d = txn_info[BW_AXI_ALEN +: MATRIX_NUM_COL];
                        alen_d     = txn_info[BW_AXI_ALEN-1:0];
                        cnt_d      = '0;
                        all_in_d   = 1'b0;
                    end
                end
                StBurst: begin
                    if (wreq_fire && last_q) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase

            if (wreq_fire) begin
                wvalid_d = 1'b0;
            end
            // A new row loads the stage. This overrides the drain in the same cycle.
            if (tensor_fire) begin
                wvalid_d = 1'b1;
                row_d    = row_fmt;
                mask_d   = col_mask_q;
                last_d   = cnt_at_alen;
                cnt_d    = cnt_q + BW_AXI_ALEN'(1);
                if (cnt_at_alen) begin
                    all_in_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rstp) begin
        if (rstp) begin
            state_q    <= StIdle;
            col_mask_q <= '0;
            alen_q     <= '0;
            cnt_q      <= '0;
            all_in_q   <= 1'b0;
            wvalid_q   <= 1'b0;
            row_q      <= '0;
            mask_q     <= '0;
            last_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_mask_q <= col_mask_d;
            alen_q     <= alen_d;
            cnt_q      <= cnt_d;
            all_in_q   <= all_in_d;
            wvalid_q   <= wvalid_d;
            row_q      <= row_d;
            mask_q     <= mask_d;
            last_q     <= last_d;
            done_q     <= done_d;
        end
    end

    assign wreq_valid = wvalid_q;
    assign wreq_row   = row_q;
    assign wreq_mask  = mask_q;
    assign wreq_last  = last_q;
    assign txn_done   = done_q;

`ifdef DCA_LSU_STORE_INVALID_CHECK_EN
    localparam logic [BW_TENSOR_SCALAR-1:0] INVALID_TENSOR_VALUE =
        BW_TENSOR_SCALAR'(get_invalid_tensor_value(TENSOR_PARA));

    logic inv_hit;
    logic inv_q, inv_d;

    always_comb begin
        inv_hit = 1'b0;
        for (int i = 0; i < int'(MATRIX_NUM_COL); i++) begin
            if (col_mask_q[i] &&
                (tensor_row[i*BW_TENSOR_SCALAR +: BW_TENSOR_SCALAR] == INVALID_TENSOR_VALUE)) begin
                inv_hit = 1'b1;
            end
        end
    end

    always_comb begin
        inv_d = inv_q | (tensor_fire & inv_hit);
        if (clear) begin
            inv_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rstp) begin
        if (rstp) begin
            inv_q <= 1'b0;
        end else begin
            inv_q <= inv_d;
        end
    end

    assign invalid_err = inv_q;
`endif

endmodule
